// File: rtl/tgt_axil_router.sv
// tgt_axil_router: routes single AXI4-Lite accesses from the PCI target master
// to one of three slaves (0 mps, 1 can, 2 uart), selected by addr[DEC_LSB+3:DEC_LSB].
// Unmapped selects answer DECERR without touching any downstream port.
// Optional build macro TGT_ROUTER_TIMEOUT_EN adds a slave-handshake timeout
// that aborts the access with SLVERR.
module tgt_axil_router #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int DEC_LSB        = 12
) (
    input  logic        core_clk,
    input  logic        ext_rst,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_aruser,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic [2:0]  m_awvalid,
    input  logic [2:0]  m_awready,
    output logic [2:0]  m_wvalid,
    input  logic [2:0]  m_wready,
    input  logic [2:0]  m_bvalid,
    output logic [2:0]  m_bready,
    output logic [2:0]  m_arvalid,
    input  logic [2:0]  m_arready,
    input  logic [2:0]  m_rvalid,
    output logic [2:0]  m_rready,
    output logic [31:0] m_awaddr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_aruser,
    input  logic [5:0]  m_bresp,
    input  logic [95:0] m_rdata,
    input  logic [5:0]  m_rresp,
    output logic        busy
);

    // Reject out-of-range timeout settings at elaboration.
    if (TIMEOUT_CYCLES < 15 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be within 15..65535");
    end

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, ERESP} state_t;

    state_t      state_q;
    logic        prio_rd_q, wlock_q, is_wr_q, mapped_q;
    logic [1:0]  sel_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q, s_rdata_q;
    logic [3:0]  wstrb_q, aruser_q;
    logic        s_awready_q, s_wready_q, s_arready_q, s_bvalid_q, s_rvalid_q;
    logic [1:0]  s_bresp_q, s_rresp_q;
    logic [2:0]  m_awvalid_q, m_wvalid_q, m_bready_q, m_arvalid_q, m_rready_q;

    logic [3:0]  aw_fld, ar_fld;
    logic        grant_w, grant_r;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [2:0]  awv_d, wv_d, oh_sel;

    function automatic logic is_mapped(input logic [3:0] fld);
        return fld < 4'd3;
    endfunction

    function automatic logic [2:0] onehot_sel(input logic [1:0] sel);
        return 3'b001 << sel;
    endfunction

    // Decode, arbitration and downstream handshake detection.
    always_comb begin
        aw_fld  = s_awaddr[DEC_LSB +: 4];
        ar_fld  = s_araddr[DEC_LSB +: 4];
        // A pending write (AW seen, W not yet) keeps the grant so a read cannot slip in.
        grant_w = s_awvalid & (wlock_q | ~s_arvalid | ~prio_rd_q);
        grant_r = s_arvalid & ~grant_w & ~wlock_q;
        oh_sel  = onehot_sel(sel_q);
        aw_hs   = |(m_awvalid_q & m_awready);
        w_hs    = |(m_wvalid_q & m_wready);
        b_hs    = |(m_bready_q & m_bvalid);
        ar_hs   = |(m_arvalid_q & m_arready);
        r_hs    = |(m_rready_q & m_rvalid);
        awv_d   = aw_hs ? 3'b000 : m_awvalid_q;
        wv_d    = w_hs  ? 3'b000 : m_wvalid_q;
    end

`ifdef TGT_ROUTER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        active, to_hit;

    // Timeout fires only while still waiting on the slave, not on the upstream master.
    always_comb begin
        active = (state_q == WADDR) || (state_q == WDATA) || (state_q == WRESP) ||
                 (state_q == RADDR) || (state_q == RDATA);
        to_hit = active && (cnt_q == 16'(TIMEOUT_CYCLES)) && !s_bvalid_q && !s_rvalid_q;
    end
`endif

    // Transaction FSM with all handshake and response outputs registered.
    always_ff @(posedge core_clk or posedge ext_rst) begin
        if (ext_rst) begin
            state_q     <= IDLE;
            prio_rd_q   <= 1'b0;
            wlock_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            mapped_q    <= 1'b0;
            sel_q       <= 2'd0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            aruser_q    <= '0;
            s_rdata_q   <= '0;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            s_arready_q <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_rvalid_q  <= 1'b0;
            s_bresp_q   <= 2'b00;
            s_rresp_q   <= 2'b00;
            m_awvalid_q <= 3'b000;
            m_wvalid_q  <= 3'b000;
            m_bready_q  <= 3'b000;
            m_arvalid_q <= 3'b000;
            m_rready_q  <= 3'b000;
`ifdef TGT_ROUTER_TIMEOUT_EN
            cnt_q       <= 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_awready_q || s_arready_q) begin
                        // Upstream handshake completes on this edge; launch downstream.
                        s_awready_q <= 1'b0;
                        s_wready_q  <= 1'b0;
                        s_arready_q <= 1'b0;
                        if (is_wr_q && mapped_q) begin
                            state_q     <= WADDR;
                            m_awvalid_q <= oh_sel;
                            m_wvalid_q  <= oh_sel;
                        end else if (is_wr_q) begin
                            state_q    <= ERESP;
                            s_bvalid_q <= 1'b1;
                            s_bresp_q  <= 2'b11;
                        end else if (mapped_q) begin
                            state_q     <= RADDR;
                            m_arvalid_q <= oh_sel;
                        end else begin
                            state_q    <= ERESP;
                            s_rvalid_q <= 1'b1;
                            s_rresp_q  <= 2'b11;
                            s_rdata_q  <= 32'hFFFF_FFFF;
                        end
                    end else if (grant_w) begin
                        if (s_wvalid) begin
                            s_awready_q <= 1'b1;
                            s_wready_q  <= 1'b1;
                            is_wr_q     <= 1'b1;
                            prio_rd_q   <= 1'b1;
                            wlock_q     <= 1'b0;
                            awaddr_q    <= s_awaddr;
                            wdata_q     <= s_wdata;
                            wstrb_q     <= s_wstrb;
                            sel_q       <= aw_fld[1:0];
                            mapped_q    <= is_mapped(aw_fld);
                        end else begin
                            wlock_q <= 1'b1;
                        end
                    end else begin
                        wlock_q <= 1'b0;
                        if (grant_r) begin
                            s_arready_q <= 1'b1;
                            is_wr_q     <= 1'b0;
                            prio_rd_q   <= 1'b0;
                            araddr_q    <= s_araddr;
                            aruser_q    <= s_aruser;
                            sel_q       <= ar_fld[1:0];
                            mapped_q    <= is_mapped(ar_fld);
                        end
                    end
                end
                WADDR: begin
                    m_awvalid_q <= awv_d;
                    m_wvalid_q  <= wv_d;
                    if (awv_d == 3'b000 && wv_d == 3'b000) begin
                        state_q    <= WRESP;
                        m_bready_q <= oh_sel;
                    end else if (awv_d == 3'b000) begin
                        state_q <= WDATA;
                    end
                end
                WDATA: begin
                    m_wvalid_q <= wv_d;
                    if (wv_d == 3'b000) begin
                        state_q    <= WRESP;
                        m_bready_q <= oh_sel;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        m_bready_q <= 3'b000;
                        s_bvalid_q <= 1'b1;
                        s_bresp_q  <= m_bresp[{sel_q, 1'b0} +: 2];
                    end else if (s_bvalid_q && s_bready) begin
                        s_bvalid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        m_arvalid_q <= 3'b000;
                        m_rready_q  <= oh_sel;
                        state_q     <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        m_rready_q <= 3'b000;
                        s_rvalid_q <= 1'b1;
                        s_rresp_q  <= m_rresp[{sel_q, 1'b0} +: 2];
                        s_rdata_q  <= m_rdata[{sel_q, 5'd0} +: 32];
                    end else if (s_rvalid_q && s_rready) begin
                        s_rvalid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                ERESP: begin
                    if ((s_bvalid_q && s_bready) || (s_rvalid_q && s_rready)) begin
                        s_bvalid_q <= 1'b0;
                        s_rvalid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef TGT_ROUTER_TIMEOUT_EN
            // Counter runs from zero on the first cycle of a downstream access.
            cnt_q <= active ? cnt_q + 16'd1 : 16'd0;
            if (to_hit) begin
                // Abandon the slave; anything it sends later finds no ready asserted.
                m_awvalid_q <= 3'b000;
                m_wvalid_q  <= 3'b000;
                m_bready_q  <= 3'b000;
                m_arvalid_q <= 3'b000;
                m_rready_q  <= 3'b000;
                state_q     <= ERESP;
                if (is_wr_q) begin
                    s_bvalid_q <= 1'b1;
                    s_bresp_q  <= 2'b10;
                end else begin
                    s_rvalid_q <= 1'b1;
                    s_rresp_q  <= 2'b10;
                    s_rdata_q  <= 32'hDEAD_BEEF;
                end
            end
`endif
        end
    end

    assign s_awready = s_awready_q;
    assign s_wready  = s_wready_q;
    assign s_arready = s_arready_q;
    assign s_bvalid  = s_bvalid_q;
    assign s_bresp   = s_bresp_q;
    assign s_rvalid  = s_rvalid_q;
    assign s_rresp   = s_rresp_q;
    assign s_rdata   = s_rdata_q;
    assign m_awvalid = m_awvalid_q;
    assign m_wvalid  = m_wvalid_q;
    assign m_bready  = m_bready_q;
    assign m_arvalid = m_arvalid_q;
    assign m_rready  = m_rready_q;
    assign m_awaddr  = awaddr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_araddr  = araddr_q;
    assign m_aruser  = aruser_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tgt_axil_router.sv
// Testbench for tgt_axil_router: table of accesses plus hand sequences for
// arbitration ties, slave stall/timeout and reset during a write response.
module tb_tgt_axil_router;

    logic        core_clk = 1'b0;
    logic        ext_rst;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, busy;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb, s_aruser;
    logic [1:0]  s_bresp, s_rresp;
    logic [2:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [2:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb, m_aruser;
    logic [5:0]  m_bresp, m_rresp;
    logic [95:0] m_rdata;

    always #5 core_clk = ~core_clk;

    tgt_axil_router #(.TIMEOUT_CYCLES(15), .DEC_LSB(12)) dut (
        .core_clk(core_clk), .ext_rst(ext_rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_aruser(s_aruser),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_araddr(m_araddr), .m_aruser(m_aruser),
        .m_bresp(m_bresp), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  user;
        int          slot;      // -1 = unmapped
        logic [1:0]  sresp;     // response the slave model returns
        int          d_a;       // ready delay on AW / AR
        int          d_w;       // ready delay on W
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic step();
        @(negedge core_clk);
    endtask

    function automatic logic [2:0] oh_of(input int slot);
        return (slot < 0) ? 3'b000 : 3'(1 << slot);
    endfunction

    // Wait for the upstream response, check it against the scoreboard, then accept it.
    task automatic finish_resp(input bit wr);
        int   n = 0;
        exp_t e;
        while (!(wr ? s_bvalid : s_rvalid) && n < 100) begin step(); n++; end
        if (!(wr ? s_bvalid : s_rvalid)) begin bound_fail("resp_wait"); return; end
        if (sb_q.size() == 0) begin bound_fail("scoreboard_empty"); return; end
        e = sb_q.pop_front();
        chk("resp_type", {63'd0, wr}, {63'd0, e.wr});
        if (wr) begin
            chk("bresp", s_bresp, e.resp);
            s_bready = 1'b1; step(); s_bready = 1'b0;
            chk("bvalid_drop", s_bvalid, 0);
        end else begin
            chk("rresp", s_rresp, e.resp);
            chk("rdata", s_rdata, e.data);
            s_rready = 1'b1; step(); s_rready = 1'b0;
            chk("rvalid_drop", s_rvalid, 0);
        end
        chk("busy_after_resp", busy, 0);
    endtask

    task automatic run_read(input vec_t v);
        logic [2:0] oh = oh_of(v.slot);
        int n = 0;
        sb_q.push_back('{wr: 1'b0, resp: v.exp_resp, data: v.exp_data});
        s_araddr = v.addr; s_aruser = v.user; s_arvalid = 1'b1;
        while (!s_arready && n < 50) begin step(); n++; end
        if (!s_arready) begin bound_fail("ar_grant"); s_arvalid = 1'b0; return; end
        chk("ar_grant_excl", s_awready, 0);
        step();
        s_arvalid = 1'b0;
        chk("m_arvalid_first", m_arvalid, oh);
        chk("ar_ready_pulse", s_arready, 0);
        if (oh != 3'b000) begin
            chk("m_araddr", m_araddr, v.addr);
            chk("m_aruser", m_aruser, v.user);
            n = 0;
            while (m_arvalid != 3'b000 && n < 60) begin
                m_arready = (n >= v.d_a) ? oh : 3'b000;
                step(); n++;
            end
            m_arready = 3'b000;
            m_rdata = '0; m_rresp = '0;
            m_rdata[v.slot*32 +: 32] = v.data;
            m_rresp[v.slot*2 +: 2]   = v.sresp;
            m_rvalid = oh;
            n = 0;
            while ((m_rready & oh) == 3'b000 && n < 60) begin step(); n++; end
            chk("m_rready", m_rready, oh);
            step();
            m_rvalid = 3'b000;
        end
        finish_resp(1'b0);
    endtask

    task automatic run_write(input vec_t v);
        logic [2:0] oh = oh_of(v.slot);
        int n = 0, ahs = 0, whs = 0;
        sb_q.push_back('{wr: 1'b1, resp: v.exp_resp, data: 32'd0});
        s_awaddr = v.addr; s_wdata = v.data; s_wstrb = v.strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        while (!s_awready && n < 50) begin step(); n++; end
        if (!s_awready) begin bound_fail("aw_grant"); s_awvalid = 1'b0; s_wvalid = 1'b0; return; end
        chk("w_grant_excl", s_arready, 0);
        chk("wready_with_awready", s_wready, 1);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("m_awvalid_first", m_awvalid, oh);
        chk("m_wvalid_first", m_wvalid, oh);
        if (oh != 3'b000) begin
            chk("m_awaddr", m_awaddr, v.addr);
            chk("m_wdata", m_wdata, v.data);
            chk("m_wstrb", m_wstrb, v.strb);
            n = 0;
            while ((m_awvalid | m_wvalid) != 3'b000 && n < 60) begin
                m_awready = (n >= v.d_a) ? oh : 3'b000;
                m_wready  = (n >= v.d_w) ? oh : 3'b000;
                if ((m_awvalid & m_awready) != 3'b000) ahs++;
                if ((m_wvalid & m_wready) != 3'b000) whs++;
                step(); n++;
            end
            m_awready = 3'b000; m_wready = 3'b000;
            chk("aw_handshakes", ahs, 1);
            chk("w_handshakes", whs, 1);
            n = 0;
            while ((m_bready & oh) == 3'b000 && n < 60) begin step(); n++; end
            chk("m_bready", m_bready, oh);
            m_bresp = '0;
            m_bresp[v.slot*2 +: 2] = v.sresp;
            m_bvalid = oh;
            step();
            m_bvalid = 3'b000;
        end
        finish_resp(1'b1);
    endtask

    initial begin
        int  n;
        int  hi;
        bit  seen;
        tbl[0] = '{1'b0, 32'h0000_1004, 32'h1234_5678, 4'h0, 4'h3, 1,  2'b00, 1, 0, 2'b00, 32'h1234_5678};
        tbl[1] = '{1'b1, 32'h0000_2010, 32'h0000_00A5, 4'h1, 4'h0, 2,  2'b00, 3, 0, 2'b00, 32'h0};
        tbl[2] = '{1'b0, 32'h0000_7000, 32'h0,         4'h0, 4'h0, -1, 2'b00, 0, 0, 2'b11, 32'hFFFF_FFFF};
        tbl[3] = '{1'b0, 32'h0000_0ABC, 32'hCAFE_F00D, 4'h0, 4'hA, 0,  2'b01, 0, 0, 2'b01, 32'hCAFE_F00D};
        tbl[4] = '{1'b1, 32'h0000_1008, 32'h5555_AAAA, 4'hF, 4'h0, 1,  2'b10, 0, 2, 2'b10, 32'h0};
        tbl[5] = '{1'b1, 32'h0000_F000, 32'h0000_0001, 4'h3, 4'h0, -1, 2'b00, 0, 0, 2'b11, 32'h0};
        tbl[6] = '{1'b0, 32'hFFFF_2FFC, 32'h0BAD_C0DE, 4'h0, 4'h5, 2,  2'b00, 2, 0, 2'b00, 32'h0BAD_C0DE};
        tbl[7] = '{1'b1, 32'h8000_0000, 32'h0F0F_0F0F, 4'hC, 4'h0, 0,  2'b00, 1, 1, 2'b00, 32'h0};

        ext_rst = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0; s_aruser = '0;
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_arready = '0; m_rvalid = '0;
        m_bresp = '0; m_rdata = '0; m_rresp = '0;
        step(); step();
        chk("reset_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m_awvalid,
                           m_wvalid, m_bready, m_arvalid, m_rready, busy}, 0);
        chk("reset_data", {m_awaddr, m_wdata}, 0);
        chk("reset_data2", {m_araddr, s_rdata, m_wstrb, m_aruser, s_bresp, s_rresp}, 0);

        // Ties from reset release: write, read, write, read.
        ext_rst = 1'b0;
        s_araddr = tbl[3].addr; s_aruser = tbl[3].user; s_arvalid = 1'b1;
        run_write(tbl[7]);
        s_awaddr = tbl[1].addr; s_wdata = tbl[1].data; s_wstrb = tbl[1].strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        run_read(tbl[3]);
        s_araddr = tbl[0].addr; s_aruser = tbl[0].user; s_arvalid = 1'b1;
        run_write(tbl[1]);
        run_read(tbl[0]);

        // Full table, one access at a time.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) run_write(tbl[i]);
            else           run_read(tbl[i]);
            step();
        end

        // mps never accepts the read address.
        s_araddr = 32'h0000_0100; s_aruser = 4'h0; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin step(); n++; end
        if (!s_arready) bound_fail("stall_grant");
        step();
        s_arvalid = 1'b0;
`ifdef TGT_ROUTER_TIMEOUT_EN
        sb_q.push_back('{wr: 1'b0, resp: 2'b10, data: 32'hDEAD_BEEF});
        hi = 0;
        while (m_arvalid != 3'b000 && hi < 100) begin hi++; step(); end
        chk("to_arvalid_cycles", hi, 16);
        chk("to_arvalid_low", m_arvalid, 0);
        m_arready = 3'b001; m_rvalid = 3'b001; m_rdata = {3{32'h1111_2222}};
        finish_resp(1'b0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (s_rvalid || m_rready != 3'b000) seen = 1'b1;
            step();
        end
        chk("to_late_resp_ignored", seen, 0);
        m_arready = 3'b000; m_rvalid = 3'b000;
`else
        for (int k = 0; k < 40; k++) step();
        chk("stall_arvalid_held", m_arvalid, 3'b001);
        chk("stall_no_resp", s_rvalid, 0);
        chk("stall_busy", busy, 1);
        sb_q.push_back('{wr: 1'b0, resp: 2'b00, data: 32'h7777_0001});
        m_arready = 3'b001; step(); m_arready = 3'b000;
        m_rdata = '0; m_rdata[31:0] = 32'h7777_0001; m_rresp = '0; m_rvalid = 3'b001;
        n = 0;
        while (m_rready == 3'b000 && n < 60) begin step(); n++; end
        step();
        m_rvalid = 3'b000;
        finish_resp(1'b0);
`endif

        // Reset while the router waits on m_bvalid.
        s_awaddr = 32'h0000_0040; s_wdata = 32'h0000_00EE; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 50) begin step(); n++; end
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        m_awready = 3'b001; m_wready = 3'b001;
        step();
        m_awready = 3'b000; m_wready = 3'b000;
        n = 0;
        while (m_bready == 3'b000 && n < 60) begin step(); n++; end
        chk("wresp_bready", m_bready, 3'b001);
        step();
        ext_rst = 1'b1;
        #1;
        chk("midrst_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m_awvalid,
                            m_wvalid, m_bready, m_arvalid, m_rready, busy}, 0);
        chk("midrst_data", {m_awaddr, m_wdata, m_wstrb}, 0);
        step();
        ext_rst = 1'b0;
        m_bvalid = 3'b001;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (s_bvalid || busy) seen = 1'b1;
            step();
        end
        chk("midrst_no_bvalid", seen, 0);
        m_bvalid = 3'b000;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
